// File: rtl/multiword_add_seq_pkg.sv
// Shared types and constants for the multi-precision adder sequencer.
// Holds the operation state enum and the word index width derivation.
package multiword_add_seq_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   // A single-word configuration still needs a 1-bit index port.
   function automatic int idx_width(input int max_words);
      return (max_words > 1) ? $clog2(max_words) : 1;
   endfunction

endpackage

// File: rtl/multiword_add_seq_rca_cin.sv
// Ripple-carry word adder with carry-in, built from a chain of full adders.
// Purely combinational; the sequencer registers its result.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

module rca_cin #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W:0] carry;

   assign carry[0] = cin;
   assign cout     = carry[W];

   generate
      for (genvar gi = 0; gi < W; gi++) begin : g_bit
         full_adder u_fa (
            .a    (a[gi]),
            .b    (b[gi]),
            .cin  (carry[gi]),
            .sum  (sum[gi]),
            .cout (carry[gi+1])
         );
      end
   endgenerate

endmodule

// File: rtl/multiword_add_seq.sv
// Multi-precision adder sequencer: adds LSW-first word pairs with a chained
// carry, emitting one registered sum word per input word.
module multiword_add_seq
   import multiword_add_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_WORDS  = 16
) (
   input  logic                             clk,
   input  logic                             resetn,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [DATA_WIDTH-1:0]            in_a,
   input  logic [DATA_WIDTH-1:0]            in_b,
   input  logic                             in_last,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DATA_WIDTH-1:0]            out_sum,
   output logic                             out_last,
   output logic                             out_carry,
   output logic [idx_width(MAX_WORDS)-1:0]  out_idx,
   output logic                             len_err
);

   localparam int             IDX_W   = idx_width(MAX_WORDS);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_WORDS - 1);

   state_t                  state_reg, state_next;
   logic                    carry_reg, carry_next;
   logic [IDX_W-1:0]        idx_reg, idx_next;
   logic                    out_valid_reg, out_valid_next;
   logic [DATA_WIDTH-1:0]   out_sum_reg, out_sum_next;
   logic                    out_last_reg, out_last_next;
   logic                    out_carry_reg, out_carry_next;
   logic [IDX_W-1:0]        out_idx_reg, out_idx_next;
   logic                    len_err_reg, len_err_next;

   logic                    accept_in;
   logic                    add_cin;
   logic [DATA_WIDTH-1:0]   add_sum;
   logic                    add_cout;

   // Carry only chains inside an operation; IDLE always starts from zero.
   assign add_cin = (state_reg == ACTIVE) && carry_reg;

   rca_cin #(
      .W (DATA_WIDTH)
   ) u_rca (
      .a    (in_a),
      .b    (in_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   assign in_ready  = !out_valid_reg || out_ready;
   assign accept_in = in_valid && in_ready;

   always_comb begin
      state_next     = state_reg;
      carry_next     = carry_reg;
      idx_next       = idx_reg;
      out_valid_next = out_valid_reg;
      out_sum_next   = out_sum_reg;
      out_last_next  = out_last_reg;
      out_carry_next = out_carry_reg;
      out_idx_next   = out_idx_reg;
      len_err_next   = len_err_reg;

      if (accept_in) begin
         out_valid_next = 1'b1;
         out_sum_next   = add_sum;
         out_idx_next   = idx_reg;
         out_last_next  = in_last;
         out_carry_next = in_last ? add_cout : 1'b0;
         if (in_last) begin
            state_next = IDLE;
            carry_next = 1'b0;
            idx_next   = '0;
         end else begin
            state_next = ACTIVE;
            carry_next = add_cout;
            // Overlong operations keep chaining the carry at the last index.
            if (idx_reg == IDX_MAX) begin
               len_err_next = 1'b1;
            end else begin
               idx_next = idx_reg + 1'b1;
            end
         end
      end else if (out_ready) begin
         out_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg     <= IDLE;
         carry_reg     <= 1'b0;
         idx_reg       <= '0;
         out_valid_reg <= 1'b0;
         out_sum_reg   <= '0;
         out_last_reg  <= 1'b0;
         out_carry_reg <= 1'b0;
         out_idx_reg   <= '0;
         len_err_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         carry_reg     <= carry_next;
         idx_reg       <= idx_next;
         out_valid_reg <= out_valid_next;
         out_sum_reg   <= out_sum_next;
         out_last_reg  <= out_last_next;
         out_carry_reg <= out_carry_next;
         out_idx_reg   <= out_idx_next;
         len_err_reg   <= len_err_next;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_sum   = out_sum_reg;
   assign out_last  = out_last_reg;
   assign out_carry = out_carry_reg;
   assign out_idx   = out_idx_reg;
   assign len_err   = len_err_reg;

endmodule
